// File: rtl/placement_checker.sv
// placement_checker: read-only legality check and wirelength report for a finished placement
//   clk, reset      : clock, synchronous active-high reset
//   start           : one-cycle pulse, begins a check when idle
//   busy, done      : run in progress / one-cycle end-of-check pulse
//   pass, err_code  : result (1 = legal) and first error class (0 none, 1 unplaced,
//   err_index       :   2 out of bounds, 3 grid mismatch, 4 occupancy) with its node or cell
//   re*/addr*/dout* : read ports of position X/Y RAMs, grid RAM and edge ROMs A/B
//   occupied        : number of grid cells not holding -1
//   wirelength      : sum over edges of |dX|+|dY|-1
//   max_len         : longest edge |dX|+|dY|
module placement_checker #(
    parameter int N_NODES = 11,
    parameter int N_EDGES = 97,
    parameter int GRID_N  = 10,
    parameter int RD_LAT  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2:0]         err_code,
    output logic [31:0]        err_index,
    output logic               rePX,
    output logic               rePY,
    output logic               reGrid,
    output logic               reEA,
    output logic               reEB,
    output logic signed [31:0] addrPX,
    output logic signed [31:0] addrPY,
    output logic signed [31:0] addrGrid,
    output logic signed [31:0] addrEA,
    output logic signed [31:0] addrEB,
    input  logic signed [31:0] doutPX,
    input  logic signed [31:0] doutPY,
    input  logic signed [31:0] doutGrid,
    input  logic signed [31:0] doutEA,
    input  logic signed [31:0] doutEB,
    output logic [31:0]        occupied,
    output logic signed [31:0] wirelength,
    output logic signed [31:0] max_len
);
    typedef enum logic [2:0] {IDLE, NODE_XY, NODE_G, GRID, EDGE_AB, EDGE_A, EDGE_B, EDGE_ACC} state_t;

    localparam logic signed [31:0] NONE      = -32'sd1;
    localparam logic signed [31:0] GN        = 32'(GRID_N);
    localparam logic [31:0]        NN        = 32'(N_NODES);
    localparam logic [31:0]        N_CELLS   = 32'(GRID_N * GRID_N);
    localparam logic [31:0]        LAST_NODE = 32'(N_NODES - 1);
    localparam logic [31:0]        LAST_CELL = 32'(GRID_N * GRID_N - 1);
    localparam logic [31:0]        LAST_EDGE = 32'(N_EDGES - 1);
    localparam logic [7:0]         LAT       = 8'(RD_LAT);

    state_t             state;
    logic [7:0]         wcnt;
    logic [31:0]        idx;
    logic signed [31:0] eb, xa, ya, xb, yb;
    logic               sample, occ_inc;
    logic [31:0]        occ_next, fidx;
    logic [2:0]         fcode;
    logic signed [31:0] dx, dy, d;

    // Every read state is entered with its strobe just raised and wcnt cleared,
    // so its data is valid exactly when wcnt reaches RD_LAT.
    always_comb begin
        sample   = state != IDLE && state != EDGE_ACC && wcnt == LAT;
        occ_inc  = doutGrid != NONE;
        occ_next = occupied + 32'd1;
        dx       = xa - xb;
        dy       = ya - yb;
        d        = (dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy);
        fcode    = 3'd0;
        fidx     = idx;
        if (sample) begin
            if (state == NODE_XY)
                fcode = (doutPX == NONE || doutPY == NONE) ? 3'd1 :
                        (doutPX < 0 || doutPX >= GN || doutPY < 0 || doutPY >= GN) ? 3'd2 : 3'd0;
            else if (state == NODE_G)
                fcode = doutGrid != $signed(idx) ? 3'd3 : 3'd0;
            else if (state == GRID && occ_inc && occupied == NN)
                fcode = 3'd4;
            else if (state == GRID && idx == LAST_CELL && (occ_inc ? occ_next : occupied) != NN) begin
                fcode = 3'd4;
                fidx  = N_CELLS;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wcnt       <= 8'd0;
            idx        <= 32'd0;
            eb         <= '0;
            xa         <= '0;
            ya         <= '0;
            xb         <= '0;
            yb         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_code   <= 3'd0;
            err_index  <= 32'd0;
            occupied   <= 32'd0;
            wirelength <= '0;
            max_len    <= '0;
            {rePX, rePY, reGrid, reEA, reEB} <= 5'd0;
            addrPX     <= '0;
            addrPY     <= '0;
            addrGrid   <= '0;
            addrEA     <= '0;
            addrEB     <= '0;
        end else begin
            {rePX, rePY, reGrid, reEA, reEB} <= 5'd0;
            done <= 1'b0;
            wcnt <= wcnt + 8'd1;
            // The overflowing cell is still counted so occupied reports N_NODES+1.
            if (state == GRID && sample && occ_inc)
                occupied <= occ_next;
            if (fcode != 3'd0) begin
                state     <= IDLE;
                busy      <= 1'b0;
                done      <= 1'b1;
                pass      <= 1'b0;
                err_code  <= fcode;
                err_index <= fidx;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_code   <= 3'd0;
                        err_index  <= 32'd0;
                        occupied   <= 32'd0;
                        wirelength <= '0;
                        max_len    <= '0;
                        idx        <= 32'd0;
                        rePX       <= 1'b1;
                        rePY       <= 1'b1;
                        addrPX     <= '0;
                        addrPY     <= '0;
                        wcnt       <= 8'd0;
                        state      <= NODE_XY;
                    end
                    NODE_XY: if (sample) begin
                        reGrid   <= 1'b1;
                        addrGrid <= doutPX * GN + doutPY;
                        wcnt     <= 8'd0;
                        state    <= NODE_G;
                    end
                    NODE_G: if (sample) begin
                        wcnt <= 8'd0;
                        if (idx == LAST_NODE) begin
                            idx      <= 32'd0;
                            reGrid   <= 1'b1;
                            addrGrid <= '0;
                            state    <= GRID;
                        end else begin
                            idx    <= idx + 32'd1;
                            rePX   <= 1'b1;
                            rePY   <= 1'b1;
                            addrPX <= $signed(idx + 32'd1);
                            addrPY <= $signed(idx + 32'd1);
                            state  <= NODE_XY;
                        end
                    end
                    GRID: if (sample) begin
                        wcnt <= 8'd0;
                        if (idx != LAST_CELL) begin
                            idx      <= idx + 32'd1;
                            reGrid   <= 1'b1;
                            addrGrid <= $signed(idx + 32'd1);
                        end else begin
                            idx    <= 32'd0;
                            reEA   <= 1'b1;
                            reEB   <= 1'b1;
                            addrEA <= '0;
                            addrEB <= '0;
                            state  <= EDGE_AB;
                        end
                    end
                    EDGE_AB: if (sample) begin
                        eb     <= doutEB;
                        rePX   <= 1'b1;
                        rePY   <= 1'b1;
                        addrPX <= doutEA;
                        addrPY <= doutEA;
                        wcnt   <= 8'd0;
                        state  <= EDGE_A;
                    end
                    EDGE_A: if (sample) begin
                        xa     <= doutPX;
                        ya     <= doutPY;
                        rePX   <= 1'b1;
                        rePY   <= 1'b1;
                        addrPX <= eb;
                        addrPY <= eb;
                        wcnt   <= 8'd0;
                        state  <= EDGE_B;
                    end
                    EDGE_B: if (sample) begin
                        xb    <= doutPX;
                        yb    <= doutPY;
                        state <= EDGE_ACC;
                    end
                    EDGE_ACC: begin
                        wirelength <= wirelength + d - 32'sd1;
                        max_len    <= d > max_len ? d : max_len;
                        if (idx == LAST_EDGE) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            pass     <= 1'b1;
                            err_code <= 3'd0;
                        end else begin
                            idx    <= idx + 32'd1;
                            reEA   <= 1'b1;
                            reEB   <= 1'b1;
                            addrEA <= $signed(idx + 32'd1);
                            addrEB <= $signed(idx + 32'd1);
                            wcnt   <= 8'd0;
                            state  <= EDGE_AB;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
